mem_stage_lsu: RTL

MEM-stage load/store unit between the EX/MEM pipeline register and M__MEMWB_Reg.
- Performs the data-memory access for the instruction held in EX/MEM over a req/ack handshake to data memory.
- Stalls the front of the pipeline while an access is outstanding.
- Presents write-back fields (RegWrite, MemToReg, MemReadData, ALUData, WBReg) to the MEM/WB register, inserting bubbles during stalls.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/mem_stage_lsu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and helpers for the MEM-stage load/store unit
package mips_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    localparam logic [3:0] BYTE_EN_WORD = 4'b1111;

    // The spare 2'b11 encoding behaves as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] size);
        case (size)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        return ((size == MEM_HALF) && addr_lo[0]) ||
               ((size == MEM_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane steering for stores and extraction for loads
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    input  logic        i_signed,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Store path: replicate data across lanes, enable only the addressed lanes.
    always_comb begin
        o_byte_en = BYTE_EN_WORD;
        o_wdata   = i_store_data;
        case (i_size)
            MEM_BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_store_data[7:0]}};
            end
            MEM_HALF: begin
                o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_store_data[15:0]}};
            end
            default: begin
                o_byte_en = BYTE_EN_WORD;
                o_wdata   = i_store_data;
            end
        endcase
        if (!i_is_store) begin
            o_byte_en = BYTE_EN_WORD;
        end
    end

    // Load path: bring the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        o_load_data = w_shifted;
        case (i_size)
            MEM_BYTE: o_load_data = i_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                             : {24'b0, w_shifted[7:0]};
            MEM_HALF: o_load_data = i_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                             : {16'b0, w_shifted[15:0]};
            default:  o_load_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with req/ack data-memory port
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)(
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic        MemRead__i,
    input  logic        MemWrite__i,
    input  logic [1:0]  MemSize__i,
    input  logic        MemSigned__i,
    input  logic [31:0] ALUData__i,
    input  logic [31:0] StoreData__i,
    input  logic        RegWrite__i,
    input  logic        MemToReg__i,
    input  logic [4:0]  WBReg__i,
    output logic        DMemReq__o,
    output logic        DMemWe__o,
    output logic [31:0] DMemAddr__o,
    output logic [3:0]  DMemByteEn__o,
    output logic [31:0] DMemWData__o,
    input  logic        DMemAck__i,
    input  logic [31:0] DMemRData__i,
    output logic        RegWrite__o,
    output logic        MemToReg__o,
    output logic [31:0] MemReadData__o,
    output logic [31:0] ALUData__o,
    output logic [4:0]  WBReg__o,
    output logic        Stall__o,
    output logic        MisalignExc__o,
    output logic        BusErr__o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state;
    lsu_state_t       w_next_state;
    logic             r_abort;
    logic [CNT_W-1:0] r_count;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_load;

    logic             w_memop;
    logic             w_misaligned;
    logic             w_start;
    logic             w_timeout;
    mem_size_t        w_size;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;

    assign w_memop      = MemRead__i | MemWrite__i;
    assign w_size       = decode_size(MemSize__i);
    assign w_misaligned = is_misaligned(w_size, ALUData__i[1:0]);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_count == TO_LAST) && !DMemAck__i;

    lsu_align u_align (
        .i_addr_lo    (ALUData__i[1:0]),
        .i_size       (w_size),
        .i_signed     (MemSigned__i),
        .i_is_store   (MemWrite__i),
        .i_store_data (StoreData__i),
        .i_rdata      (DMemRData__i),
        .o_byte_en    (w_byte_en),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign DMemReq__o    = r_req;
    assign DMemWe__o     = r_we;
    assign DMemAddr__o   = r_addr;
    assign DMemByteEn__o = r_be;
    assign DMemWData__o  = r_wdata;
    assign ALUData__o    = ALUData__i;
    assign WBReg__o      = WBReg__i;

    // State register; reset drops any outstanding access immediately.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, stall and bubble insertion toward MEM/WB.
    always_comb begin
        w_next_state   = r_state;
        w_start        = 1'b0;
        Stall__o       = 1'b0;
        RegWrite__o    = RegWrite__i;
        MemToReg__o    = MemToReg__i;
        MemReadData__o = 32'b0;
        MisalignExc__o = 1'b0;
        BusErr__o      = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_memop && w_misaligned) begin
                    MisalignExc__o = 1'b1;
                    RegWrite__o    = 1'b0;
                end else if (w_memop) begin
                    w_start      = 1'b1;
                    w_next_state = LSU_REQ;
                    Stall__o     = 1'b1;
                    RegWrite__o  = 1'b0;
                    MemToReg__o  = 1'b0;
                end
            end
            LSU_REQ: begin
                Stall__o    = 1'b1;
                RegWrite__o = 1'b0;
                MemToReg__o = 1'b0;
                if (DMemAck__i) begin
                    w_next_state = LSU_DONE;
                end else if (w_timeout) begin
                    BusErr__o    = 1'b1;
                    w_next_state = LSU_DONE;
                end
            end
            LSU_DONE: begin
                MemReadData__o = r_load;
                RegWrite__o    = RegWrite__i & ~r_abort;
                w_next_state   = LSU_IDLE;
            end
            default: begin
                w_next_state = LSU_IDLE;
            end
        endcase
    end

    // Request registers, wait counter and load-data capture.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'b0;
            r_be    <= 4'b0;
            r_wdata <= 32'b0;
            r_load  <= 32'b0;
            r_count <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite__i;
                        r_addr  <= {ALUData__i[31:2], 2'b00};
                        r_be    <= w_byte_en;
                        r_wdata <= w_wdata;
                        r_count <= '0;
                        r_abort <= 1'b0;
                    end
                end
                LSU_REQ: begin
                    r_count <= r_count + CNT_W'(1);
                    if (DMemAck__i) begin
                        r_req  <= 1'b0;
                        r_load <= w_load_data;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_load  <= 32'b0;
                        r_abort <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
